// File: rtl/mean_pkg.sv
// Shared types for the mean datapath: sample width and sample type.
package mean_pkg;
  localparam int c_data_width = 16;
  typedef logic signed [c_data_width-1:0] t_data;
endpackage

// File: rtl/mean_frame_gatherer.sv
// Serial-to-parallel framer for the mean datapath: packs BUS_WIDTH samples per
// frame, checks alignment against s_last, discards malformed frames and resyncs.
module mean_frame_gatherer
  import mean_pkg::*;
#(
  parameter int BUS_WIDTH = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  input  logic                 s_valid,
  input  t_data                s_data,
  input  logic                 s_last,
  output logic                 o_valid,
  output t_data                o_data [0:BUS_WIDTH-1],
  output logic                 o_err,
  output logic [CNT_WIDTH-1:0] o_frame_cnt
);

  localparam int IDX_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUS_WIDTH - 1);

  if (BUS_WIDTH < 1) begin : g_bad_bus_width
    $error("mean_frame_gatherer: BUS_WIDTH must be >= 1");
  end

  typedef enum logic {COLLECT, RESYNC} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             stage_wr;
  logic             frame_done;
  logic             frame_err;
  t_data            stage [0:BUS_WIDTH-1];

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    stage_wr   = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    if (i_flush) begin
      state_nxt = COLLECT;
      idx_nxt   = '0;
    end else if (s_valid) begin
      unique case (state)
        COLLECT: begin
          if (idx == LAST_IDX) begin
            idx_nxt = '0;
            if (s_last) begin
              frame_done = 1'b1;
            end else begin
              frame_err = 1'b1;
              state_nxt = RESYNC;
            end
          end else begin
            stage_wr = 1'b1;
            if (s_last) begin
              frame_err = 1'b1;
              idx_nxt   = '0;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end
        end
        RESYNC: begin
          // Samples are dropped until a last marks the next frame boundary.
          if (s_last) begin
            state_nxt = COLLECT;
            idx_nxt   = '0;
          end
        end
        default: begin
          state_nxt = COLLECT;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Output register stage: one cycle from completing sample to o_valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= COLLECT;
      idx         <= '0;
      o_valid     <= 1'b0;
      o_err       <= 1'b0;
      o_frame_cnt <= '0;
      for (int i = 0; i < BUS_WIDTH; i++) o_data[i] <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      o_valid <= frame_done;
      o_err   <= frame_err;
      if (frame_done) begin
        o_frame_cnt <= o_frame_cnt + CNT_WIDTH'(1);
        for (int i = 0; i < BUS_WIDTH - 1; i++) o_data[i] <= stage[i];
        o_data[BUS_WIDTH-1] <= s_data;
      end
    end
  end

  // Staging buffer holds pure data; its contents only matter once idx says so.
  always_ff @(posedge clk) begin
    if (stage_wr) stage[idx] <= s_data;
  end

endmodule

// File: tb/tb_mean_frame_gatherer.sv
// Bench for mean_frame_gatherer: two configurations (BUS_WIDTH=2/CNT_WIDTH=16
// and BUS_WIDTH=3/CNT_WIDTH=2) driven by shared stimulus, checked against a frame model.
module tb_mean_frame_gatherer;
  import mean_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_flush = 1'b0;
  logic        s_valid = 1'b0;
  t_data       s_data = '0;
  logic        s_last = 1'b0;

  logic        o_valid2, o_err2;
  t_data       o_data2 [0:1];
  logic [15:0] o_frame_cnt2;
  logic        o_valid3, o_err3;
  t_data       o_data3 [0:2];
  logic [1:0]  o_frame_cnt3;

  int n_vec = 0;
  int n_err = 0;

  mean_frame_gatherer #(.BUS_WIDTH(2), .CNT_WIDTH(16)) dut2 (
    .clk(clk), .rst(rst), .i_flush(i_flush), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .o_valid(o_valid2), .o_data(o_data2), .o_err(o_err2),
    .o_frame_cnt(o_frame_cnt2));

  mean_frame_gatherer #(.BUS_WIDTH(3), .CNT_WIDTH(2)) dut3 (
    .clk(clk), .rst(rst), .i_flush(i_flush), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .o_valid(o_valid3), .o_data(o_data3), .o_err(o_err3),
    .o_frame_cnt(o_frame_cnt3));

  always #5 clk = ~clk;

  // Reference model: index 0 = BUS_WIDTH 2 / mod 65536, index 1 = BUS_WIDTH 3 / mod 4
  int    bw  [2] = '{2, 3};
  int    mdl [2] = '{65536, 4};
  t_data fq  [2][0:2];
  int    fn  [2];
  bit    rs  [2];
  bit    ev  [2];
  bit    ee  [2];
  t_data ed  [2][0:2];
  int    ec  [2];

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      fn[c] = 0; rs[c] = 0; ev[c] = 0; ee[c] = 0; ec[c] = 0;
      for (int i = 0; i < 3; i++) ed[c][i] = '0;
    end
  endfunction

  function automatic void model_update(int c, logic v, t_data d, logic l, logic f);
    ev[c] = 0;
    ee[c] = 0;
    if (f) begin
      fn[c] = 0;
      rs[c] = 0;
    end else if (v) begin
      if (rs[c]) begin
        if (l) rs[c] = 0;
      end else begin
        fq[c][fn[c]] = d;
        fn[c]++;
        if (l) begin
          if (fn[c] == bw[c]) begin
            for (int i = 0; i < bw[c]; i++) ed[c][i] = fq[c][i];
            ec[c] = (ec[c] + 1) % mdl[c];
            ev[c] = 1;
          end else begin
            ee[c] = 1;
          end
          fn[c] = 0;
        end else if (fn[c] == bw[c]) begin
          ee[c] = 1;
          rs[c] = 1;
          fn[c] = 0;
        end
      end
    end
  endfunction

  task automatic step(input logic v, input t_data d, input logic l, input logic f);
    @(negedge clk);
    s_valid = v; s_data = d; s_last = l; i_flush = f;
    @(posedge clk);
    model_update(0, v, d, l, f);
    model_update(1, v, d, l, f);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_valid = 0; s_last = 0; i_flush = 0; s_data = '0;
    rst = 0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++;
    if (o_valid2 !== 1'b0 || o_err2 !== 1'b0 || o_frame_cnt2 !== 16'd0 ||
        o_data2[0] !== 16'sd0 || o_data2[1] !== 16'sd0) begin
      n_err++;
      $display("FAIL reset_bw2: valid=%0b err=%0b cnt=%0d d0=%h d1=%h, want all 0",
               o_valid2, o_err2, o_frame_cnt2, o_data2[0], o_data2[1]);
    end
    n_vec++;
    if (o_valid3 !== 1'b0 || o_err3 !== 1'b0 || o_frame_cnt3 !== 2'd0 ||
        o_data3[0] !== 16'sd0 || o_data3[1] !== 16'sd0 || o_data3[2] !== 16'sd0) begin
      n_err++;
      $display("FAIL reset_bw3: valid=%0b err=%0b cnt=%0d, want all 0",
               o_valid3, o_err3, o_frame_cnt3);
    end
  endtask

  task automatic test_single_frame();
    step(1, 16'h10, 0, 0);
    n_vec++;
    if (o_valid2 !== 1'b0) begin
      n_err++; $display("FAIL single_early_valid: got %0b want 0", o_valid2);
    end
    step(1, 16'h20, 1, 0);
    n_vec++;
    if (o_valid2 !== 1'b1 || o_data2[0] !== 16'sh10 || o_data2[1] !== 16'sh20 ||
        o_frame_cnt2 !== 16'd1) begin
      n_err++;
      $display("FAIL single_frame: valid=%0b data={%h,%h} cnt=%0d want 1 {0010,0020} 1",
               o_valid2, o_data2[0], o_data2[1], o_frame_cnt2);
    end
    step(0, 16'h0, 0, 0);
    n_vec++;
    if (o_valid2 !== 1'b0 || o_data2[1] !== 16'sh20) begin
      n_err++;
      $display("FAIL single_pulse_hold: valid=%0b d1=%h want 0 0020", o_valid2, o_data2[1]);
    end
  endtask

  task automatic test_back_to_back();
    step(0, 16'h0, 0, 1);
    for (int k = 1; k <= 6; k++) begin
      step(1, t_data'(k), (k % 2) == 0, 0);
      n_vec++;
      if ((k % 2) == 0) begin
        if (o_valid2 !== 1'b1 || o_data2[0] !== t_data'(k - 1) || o_data2[1] !== t_data'(k)) begin
          n_err++;
          $display("FAIL b2b_frame%0d: valid=%0b data={%h,%h} want 1 {%h,%h}",
                   k / 2, o_valid2, o_data2[0], o_data2[1], k - 1, k);
        end
      end else if (o_valid2 !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_gap%0d: valid=%0b want 0", k, o_valid2);
      end
    end
  endtask

  task automatic test_premature_last();
    step(0, 16'h0, 0, 1);
    step(1, 16'h7, 1, 0);
    n_vec++;
    if (o_err3 !== 1'b1 || o_valid3 !== 1'b0) begin
      n_err++; $display("FAIL premature_err: err=%0b valid=%0b want 1 0", o_err3, o_valid3);
    end
    step(1, 16'h8, 0, 0);
    step(1, 16'h9, 0, 0);
    step(1, 16'hA, 1, 0);
    n_vec++;
    if (o_valid3 !== 1'b1 || o_err3 !== 1'b0 || o_data3[0] !== 16'sh8 ||
        o_data3[1] !== 16'sh9 || o_data3[2] !== 16'shA) begin
      n_err++;
      $display("FAIL premature_recover: valid=%0b err=%0b data={%h,%h,%h} want 1 0 {8,9,a}",
               o_valid3, o_err3, o_data3[0], o_data3[1], o_data3[2]);
    end
  endtask

  task automatic test_missing_last();
    int errs;
    int vals;
    do_reset();
    errs = 0; vals = 0;
    for (int k = 1; k <= 6; k++) begin
      step(1, t_data'(k), (k == 4) || (k == 6), 0);
      errs += int'(o_err2);
      if (k < 6) vals += int'(o_valid2);
    end
    n_vec++;
    if (o_valid2 !== 1'b1 || o_data2[0] !== 16'sh5 || o_data2[1] !== 16'sh6 ||
        o_frame_cnt2 !== 16'd1 || errs != 1 || vals != 0) begin
      n_err++;
      $display("FAIL missing_last: valid=%0b data={%h,%h} cnt=%0d errs=%0d early_valids=%0d want 1 {5,6} 1 1 0",
               o_valid2, o_data2[0], o_data2[1], o_frame_cnt2, errs, vals);
    end
  endtask

  task automatic test_flush();
    do_reset();
    step(1, 16'hAA, 0, 0);
    step(0, 16'h0, 0, 1);
    n_vec++;
    if (o_valid2 !== 1'b0 || o_err2 !== 1'b0) begin
      n_err++; $display("FAIL flush_quiet: valid=%0b err=%0b want 0 0", o_valid2, o_err2);
    end
    step(1, 16'h01, 0, 0);
    step(1, 16'h02, 1, 0);
    n_vec++;
    if (o_valid2 !== 1'b1 || o_err2 !== 1'b0 || o_data2[0] !== 16'sh01 ||
        o_data2[1] !== 16'sh02 || o_frame_cnt2 !== 16'd1) begin
      n_err++;
      $display("FAIL flush_frame: valid=%0b err=%0b data={%h,%h} cnt=%0d want 1 0 {01,02} 1",
               o_valid2, o_err2, o_data2[0], o_data2[1], o_frame_cnt2);
    end
    // Flush together with a completing sample: the sample must be dropped.
    step(1, 16'h33, 0, 0);
    step(1, 16'h55, 1, 1);
    n_vec++;
    if (o_valid2 !== 1'b0 || o_err2 !== 1'b0 || o_data2[1] !== 16'sh02 ||
        o_frame_cnt2 !== 16'd1) begin
      n_err++;
      $display("FAIL flush_same_cycle: valid=%0b err=%0b d1=%h cnt=%0d want 0 0 02 1",
               o_valid2, o_err2, o_data2[1], o_frame_cnt2);
    end
  endtask

  task automatic test_cnt_wrap();
    logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int f = 0; f < 5; f++) begin
      step(1, t_data'(3 * f + 1), 0, 0);
      step(1, t_data'(3 * f + 2), 0, 0);
      step(1, t_data'(3 * f + 3), 1, 0);
      n_vec++;
      if (o_valid3 !== 1'b1 || o_frame_cnt3 !== want[f]) begin
        n_err++;
        $display("FAIL cnt_wrap%0d: valid=%0b cnt=%0d want 1 %0d", f, o_valid3, o_frame_cnt3, want[f]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    step(1, 16'h61, 0, 0);
    step(1, 16'h62, 1, 0);
    step(1, 16'h77, 0, 0);
    rst = 0;
    #1;
    n_vec++;
    if (o_valid2 !== 1'b0 || o_err2 !== 1'b0 || o_frame_cnt2 !== 16'd0 ||
        o_data2[0] !== 16'sd0 || o_data2[1] !== 16'sd0 || o_frame_cnt3 !== 2'd0) begin
      n_err++;
      $display("FAIL reset_async: valid=%0b err=%0b cnt=%0d data={%h,%h} cnt3=%0d want all 0",
               o_valid2, o_err2, o_frame_cnt2, o_data2[0], o_data2[1], o_frame_cnt3);
    end
    s_valid = 0; s_last = 0;
    model_reset();
    @(negedge clk);
    rst = 1;
    step(1, 16'h31, 0, 0);
    step(1, 16'h32, 1, 0);
    n_vec++;
    if (o_valid2 !== 1'b1 || o_data2[0] !== 16'sh31 || o_data2[1] !== 16'sh32 ||
        o_frame_cnt2 !== 16'd1) begin
      n_err++;
      $display("FAIL reset_restart: valid=%0b data={%h,%h} cnt=%0d want 1 {31,32} 1",
               o_valid2, o_data2[0], o_data2[1], o_frame_cnt2);
    end
  endtask

  task automatic test_random();
    bit bad;
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, t_data'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 31) == 0);
      bad = (o_valid2 !== ev[0]) || (o_err2 !== ee[0]) || (o_frame_cnt2 !== 16'(ec[0]));
      for (int i = 0; i < 2; i++) if (o_data2[i] !== ed[0][i]) bad = 1;
      n_vec++;
      if (bad) begin
        n_err++;
        $display("FAIL random_bw2 @%0d: valid=%0b err=%0b cnt=%0d data={%h,%h} want %0b %0b %0d {%h,%h}",
                 n, o_valid2, o_err2, o_frame_cnt2, o_data2[0], o_data2[1],
                 ev[0], ee[0], ec[0], ed[0][0], ed[0][1]);
      end
      bad = (o_valid3 !== ev[1]) || (o_err3 !== ee[1]) || (o_frame_cnt3 !== 2'(ec[1]));
      for (int i = 0; i < 3; i++) if (o_data3[i] !== ed[1][i]) bad = 1;
      n_vec++;
      if (bad) begin
        n_err++;
        $display("FAIL random_bw3 @%0d: valid=%0b err=%0b cnt=%0d data={%h,%h,%h} want %0b %0b %0d {%h,%h,%h}",
                 n, o_valid3, o_err3, o_frame_cnt3, o_data3[0], o_data3[1], o_data3[2],
                 ev[1], ee[1], ec[1], ed[1][0], ed[1][1], ed[1][2]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_premature_last();
    test_missing_last();
    test_flush();
    test_cnt_wrap();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
